modexp_sequencer: RTL and testbench

Control sequencer for the square-and-multiply modular-exponentiation datapath on the MAX10 hardware-test board. It latches an exponent on a start request and initialises the accumulator (z = 1). It then presents exponent bits MSB-first, one per accepted step, over a valid/ready handshake. It finishes each run with one write strobe into the 64-bit capture RAM and advances the RAM address. This replaces the free-running bit counter with a deterministic, restartable, handshake-driven schedule.

---
 rtl/modexp_sequencer.sv | 121 ++++++++++++
 tb/tb_modexp_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_sequencer.sv
// Handshake-driven control sequencer for the square-and-multiply modexp datapath.
// Optional build macro MODEXP_SEQ_LEADZERO_SKIP_EN: skip leading-zero exponent bits.
module modexp_sequencer #(
  parameter int EXP_W  = 8,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [EXP_W-1:0]  e,
  output logic              busy,
  output logic              init,
  output logic              step_valid,
  output logic              e_bit,
  input  logic              step_ready,
  output logic              cap_we,
  output logic [ADDR_W-1:0] cap_addr,
  output logic              done
);

  localparam int IDX_W = $clog2(EXP_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_STEP,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [EXP_W-1:0]  e_lat_q, e_lat_d;
  logic [IDX_W-1:0]  bit_idx_q, bit_idx_d;
  logic [ADDR_W-1:0] cap_addr_q, cap_addr_d;
  logic [IDX_W-1:0]  first_idx;
  logic              skip_to_capture;
  logic              handshake;

`ifdef MODEXP_SEQ_LEADZERO_SKIP_EN
  // Priority scan: the last set bit seen while counting up is the highest one.
  always_comb begin
    first_idx = '0;
    for (int i = 0; i < EXP_W; i++) begin
      if (e_lat_q[i]) first_idx = IDX_W'(i);
    end
  end
  assign skip_to_capture = (e_lat_q == '0);
`else
  assign first_idx       = IDX_W'(EXP_W - 1);
  assign skip_to_capture = 1'b0;
`endif

  assign handshake = step_valid && step_ready;

  // NOTE: state only changes in always_ff with non-blocking assignments; the
  // comb blocks use blocking assignments so later lines see earlier results.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      e_lat_q    <= '0;
      bit_idx_q  <= '0;
      cap_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      e_lat_q    <= e_lat_d;
      bit_idx_q  <= bit_idx_d;
      cap_addr_q <= cap_addr_d;
    end
  end

  // NOTE: every comb output gets a default first so no path leaves it unassigned
  // (which would infer a latch).
  always_comb begin
    state_d    = state_q;
    e_lat_d    = e_lat_q;
    bit_idx_d  = bit_idx_q;
    cap_addr_d = cap_addr_q;
    if (state_q != S_IDLE && abort) begin
      // Abort wins over a same-cycle handshake or capture.
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            e_lat_d = e;
            state_d = S_INIT;
          end
        end
        S_INIT: begin
          bit_idx_d = first_idx;
          state_d   = skip_to_capture ? S_CAPTURE : S_STEP;
        end
        S_STEP: begin
          if (handshake) begin
            if (bit_idx_q == '0) state_d = S_CAPTURE;
            else                 bit_idx_d = bit_idx_q - IDX_W'(1);
          end
        end
        S_CAPTURE: begin
          cap_addr_d = cap_addr_q + ADDR_W'(1);
          state_d    = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    init       = (state_q == S_INIT);
    step_valid = (state_q == S_STEP);
    e_bit      = step_valid ? e_lat_q[bit_idx_q] : 1'b0;
    cap_we     = (state_q == S_CAPTURE) && !abort;
    done       = (state_q == S_DONE) && !abort;
  end

  assign cap_addr = cap_addr_q;

endmodule

// File: tb/tb_modexp_sequencer.sv
// Self-checking bench for modexp_sequencer: queue-based run model checked every
// cycle, plus directed runs with hand-computed cycle-mask expectations.
module tb_modexp_sequencer;

  localparam int EXP_W  = 8;
  localparam int ADDR_W = 5;

  localparam int PH_IDLE = 0;
  localparam int PH_INIT = 1;
  localparam int PH_STEP = 2;
  localparam int PH_CAP  = 3;
  localparam int PH_DONE = 4;

  logic              clk = 1'b0;
  logic              rst, start, abort, step_ready;
  logic [EXP_W-1:0]  e;
  logic              busy, init, step_valid, e_bit, cap_we, done;
  logic [ADDR_W-1:0] cap_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  modexp_sequencer #(.EXP_W(EXP_W), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .e          (e),
    .busy       (busy),
    .init       (init),
    .step_valid (step_valid),
    .e_bit      (e_bit),
    .step_ready (step_ready),
    .cap_we     (cap_we),
    .cap_addr   (cap_addr),
    .done       (done)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Run model: a run is the list of exponent bits still to be issued.
  int               m_phase = PH_IDLE;
  bit               m_bits[$];
  logic [EXP_W-1:0] m_e;
  int               m_addr  = 0;
  bit               m_live  = 1'b0;

  always @(negedge clk) begin
    if (m_live) begin
      check("busy",       busy,       m_phase != PH_IDLE);
      check("init",       init,       m_phase == PH_INIT);
      check("step_valid", step_valid, m_phase == PH_STEP);
      check("e_bit",      e_bit,      (m_phase == PH_STEP) ? m_bits[0] : 1'b0);
      check("cap_we",     cap_we,     (m_phase == PH_CAP) && !abort);
      check("done",       done,       (m_phase == PH_DONE) && !abort);
      check("cap_addr",   cap_addr,   m_addr);
    end
    if (rst) begin
      m_phase = PH_IDLE;
      m_addr  = 0;
      m_bits.delete();
      m_live  = 1'b1;
    end else if (m_live) begin
      if (m_phase != PH_IDLE && abort) begin
        m_phase = PH_IDLE;
      end else begin
        case (m_phase)
          PH_IDLE: if (start) begin m_e = e; m_phase = PH_INIT; end
          PH_INIT: begin
            m_bits.delete();
            for (int i = EXP_W - 1; i >= 0; i--) m_bits.push_back(m_e[i]);
`ifdef MODEXP_SEQ_LEADZERO_SKIP_EN
            while (m_bits.size() > 0 && m_bits[0] == 1'b0) void'(m_bits.pop_front());
`endif
            m_phase = (m_bits.size() == 0) ? PH_CAP : PH_STEP;
          end
          PH_STEP: if (step_ready) begin
            void'(m_bits.pop_front());
            if (m_bits.size() == 0) m_phase = PH_CAP;
          end
          PH_CAP: begin
            m_addr  = (m_addr + 1) % (1 << ADDR_W);
            m_phase = PH_DONE;
          end
          default: m_phase = PH_IDLE;
        endcase
      end
    end
  end

  // Per-run cycle logs, bit r = value in cycle r after the start cycle.
  logic [63:0]       lg_init, lg_valid, lg_ebit, lg_cap, lg_done, lg_busy, lg_stream;
  logic [ADDR_W-1:0] lg_capaddr;
  int                rel;

  task automatic clear_log();
    lg_init = '0; lg_valid = '0; lg_ebit = '0; lg_cap = '0;
    lg_done = '0; lg_busy = '0; lg_stream = '0; lg_capaddr = '1; rel = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rel < 64) begin
      lg_init[rel]  = init;
      lg_valid[rel] = step_valid;
      lg_ebit[rel]  = e_bit;
      lg_cap[rel]   = cap_we;
      lg_done[rel]  = done;
      lg_busy[rel]  = busy;
      if (cap_we) lg_capaddr = cap_addr;
      if (step_valid && step_ready && !abort) lg_stream = {lg_stream[62:0], e_bit};
    end
    rel++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ncap;
    int budget;
    rst = 1'b1; start = 1'b0; abort = 1'b0; step_ready = 1'b1; e = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {busy, init, step_valid, e_bit, cap_we, done, cap_addr}, '0);
    rst = 1'b0;

    // Run A: e=0F, no stalls.
    clear_log();
    e = 8'h0F; start = 1'b1; tick();
    start = 1'b0; e = EXP_W'($urandom);
    repeat (15) tick();
    check("A_init", lg_init, 64'h2);
`ifdef MODEXP_SEQ_LEADZERO_SKIP_EN
    check("A_valid",  lg_valid,  64'h3C);
    check("A_ebit",   lg_ebit,   64'h3C);
    check("A_stream", lg_stream, 64'hF);
    check("A_cap",    lg_cap,    64'h40);
    check("A_done",   lg_done,   64'h80);
    check("A_busy",   lg_busy,   64'hFE);
`else
    check("A_valid",  lg_valid,  64'h3FC);
    check("A_ebit",   lg_ebit,   64'h3C0);
    check("A_stream", lg_stream, 64'h0F);
    check("A_cap",    lg_cap,    64'h400);
    check("A_done",   lg_done,   64'h800);
    check("A_busy",   lg_busy,   64'hFFE);
`endif
    check("A_capaddr", lg_capaddr, 0);
    check("A_addr_after", cap_addr, 1);

    // Run B: e=00.
    clear_log();
    e = 8'h00; start = 1'b1; tick();
    start = 1'b0;
    repeat (15) tick();
`ifdef MODEXP_SEQ_LEADZERO_SKIP_EN
    check("B_valid", lg_valid, 64'h0);
    check("B_cap",   lg_cap,   64'h4);
    check("B_done",  lg_done,  64'h8);
`else
    check("B_valid", lg_valid, 64'h3FC);
    check("B_ebit",  lg_ebit,  64'h0);
    check("B_cap",   lg_cap,   64'h400);
    check("B_done",  lg_done,  64'h800);
`endif
    check("B_capaddr", lg_capaddr, 1);

    // Run C: e=A5, step_ready low for three cycles during the second step.
    clear_log();
    e = 8'hA5; start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    step_ready = 1'b0; repeat (3) tick();
    step_ready = 1'b1; repeat (12) tick();
    check("C_valid",  lg_valid,  64'h1FFC);
    check("C_ebit",   lg_ebit,   64'h1484);
    check("C_stream", lg_stream, 64'hA5);
    check("C_cap",    lg_cap,    64'h2000);
    check("C_done",   lg_done,   64'h4000);
    check("C_capaddr", lg_capaddr, 2);

    // Run D: abort on the 5th handshake, then a clean run with start pulses
    // while busy and in DONE that must be ignored.
    check("D_addr_before", cap_addr, 3);
    clear_log();
    e = 8'hFF; start = 1'b1; tick();
    start = 1'b0; repeat (5) tick();
    abort = 1'b1; tick();
    abort = 1'b0; repeat (9) tick();
    check("D_busy",   lg_busy,   64'h7E);
    check("D_valid",  lg_valid,  64'h7C);
    check("D_stream", lg_stream, 64'hF);
    check("D_cap",    lg_cap,    64'h0);
    check("D_done",   lg_done,   64'h0);
    check("D_addr_after", cap_addr, 3);
    clear_log();
    e = 8'hFF; start = 1'b1; tick();
    start = 1'b0; tick(); tick();
    start = 1'b1; tick();
    start = 1'b0; repeat (7) tick();
    start = 1'b1; tick();
    start = 1'b0; repeat (4) tick();
    check("E_busy",    lg_busy,    64'hFFE);
    check("E_cap",     lg_cap,     64'h400);
    check("E_done",    lg_done,    64'h800);
    check("E_capaddr", lg_capaddr, 3);

    // Run F: reset in cycle 4 of a run.
    clear_log();
    e = 8'hC3; start = 1'b1; tick();
    start = 1'b0; repeat (3) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    check("F_outputs", {busy, init, step_valid, e_bit, cap_we, done, cap_addr}, '0);
    check("F_busy", lg_busy, 64'h1E);
    repeat (2) tick();

    // Wrap: 33 back-to-back runs with start held high.
    ncap = 0;
    budget = 0;
    start = 1'b1;
    while (ncap < 33 && budget < 600) begin
      @(negedge clk);
      if (cap_we) begin
        check("wrap_addr", cap_addr, ncap % 32);
        ncap++;
      end
      @(posedge clk);
      #1;
      e = EXP_W'($urandom);
      budget++;
    end
    start = 1'b0;
    check("wrap_runs", ncap, 33);

    // Random traffic, checked every cycle by the run model.
    for (int c = 0; c < 4000; c++) begin
      start      = ($urandom_range(0, 3) == 0);
      abort      = ($urandom_range(0, 39) == 0);
      step_ready = ($urandom_range(0, 2) != 0);
      rst        = ($urandom_range(0, 499) == 0);
      e          = EXP_W'($urandom);
      @(posedge clk);
      #1;
    end
    start = 1'b0; abort = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
